// File: rtl/program_counter.sv
// Fetch-stage PC sequencer for the RV32I core: fetch handshake, PC advance and redirect buffering.
// Optional misaligned-redirect trap enabled by defining MISALIGN_TRAP_EN.
module program_counter #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcplus4_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] fetch_count_o,
    output logic        misalign_o,
    output logic [31:0] bad_addr_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   count_d;
    logic [XLEN-1:0]   latched;
    logic [XLEN-1:0]   latched_d;
    logic              load_en;
    logic [XLEN-1:0]   load_addr;

    // Valid is a pure decode of the registered state, so it never glitches with inputs.
    assign fetch_valid_o = (state != BOOT);

    // Next-state and sequencing decisions; redirect wins over stall and advance.
    always_comb begin
        state_d   = state;
        count_d   = fetch_count_o;
        latched_d = latched;
        load_en   = 1'b0;
        load_addr = redirect_target_i;
        case (state)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_valid_i) begin
                    if (fetch_ready_i) begin
                        load_en = 1'b1;
                    end else begin
                        latched_d = redirect_target_i;
                        state_d   = PEND;
                    end
                end else if (fetch_ready_i && !stall_i) begin
                    count_d = fetch_count_o + XLEN'(1);
                end
            end
            PEND: begin
                if (fetch_ready_i) begin
                    load_en   = 1'b1;
                    load_addr = redirect_valid_i ? redirect_target_i : latched;
                    state_d   = RUN;
                end else if (redirect_valid_i) begin
                    latched_d = redirect_target_i;
                end
            end
            default: state_d = BOOT;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic              misalign_d;
    logic [XLEN-1:0]   bad_addr_d;

    // A misaligned target is diverted to the trap vector and recorded.
    always_comb begin
        pc_d       = pc_o;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_o;
        if (load_en) begin
            if (load_addr[1:0] != 2'b00) begin
                pc_d       = TRAP_VECTOR;
                bad_addr_d = load_addr;
                misalign_d = 1'b1;
            end else begin
                pc_d = load_addr;
            end
        end else if (count_d != fetch_count_o) begin
            pc_d = pcplus4_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_o <= 1'b0;
            bad_addr_o <= '0;
        end else begin
            misalign_o <= misalign_d;
            bad_addr_o <= bad_addr_d;
        end
    end
`else
    // Without the trap, the low target bits are simply dropped on load.
    always_comb begin
        pc_d = pc_o;
        if (load_en) begin
            pc_d = load_addr & ~XLEN'(3);
        end else if (count_d != fetch_count_o) begin
            pc_d = pcplus4_i;
        end
    end

    assign misalign_o = 1'b0;
    assign bad_addr_o = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= BOOT;
            pc_o          <= RESET_VECTOR;
            fetch_count_o <= '0;
            latched       <= '0;
        end else begin
            state         <= state_d;
            pc_o          <= pc_d;
            fetch_count_o <= count_d;
            latched       <= latched_d;
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed scenarios plus randomized traffic vs a behavioural model.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_program_counter;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcplus4 = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        fetch_ready = 1'b0;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] fetch_count;
    logic        misalign;
    logic [31:0] bad_addr;

    program_counter #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk               (clk),
        .rst               (rst),
        .pcplus4_i         (pcplus4),
        .stall_i           (stall),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .fetch_ready_i     (fetch_ready),
        .fetch_valid_o     (fetch_valid),
        .pc_o              (pc),
        .fetch_count_o     (fetch_count),
        .misalign_o        (misalign),
        .bad_addr_o        (bad_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        mis;
        logic [31:0] bad;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Behavioural model: what the fetch unit has promised so far.
    bit          m_booted;
    bit          m_pending;
    logic [31:0] m_pending_tgt;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic [31:0] m_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_go_to(input logic [31:0] tgt);
`ifdef MISALIGN_TRAP_EN
        if (tgt % 4 != 0) begin
            m_pc  = TV;
            m_bad = tgt;
            m_mis = 1'b1;
        end else begin
            m_pc = tgt;
        end
`else
        m_pc = tgt - (tgt % 4);
`endif
    endtask

    task automatic model_reset();
        m_booted  = 0;
        m_pending = 0;
        m_pending_tgt = '0;
        m_pc  = RV;
        m_cnt = 0;
        m_mis = 0;
        m_bad = 0;
    endtask

    // Apply one cycle of stimulus at the falling edge and queue the post-edge prediction.
    task automatic cycle(input bit r, input bit rdy, input bit stl, input bit rv, input logic [31:0] tgt);
        @(negedge clk);
        rst             = r;
        fetch_ready     = rdy;
        stall           = stl;
        redirect_valid  = rv;
        redirect_target = tgt;
        pcplus4         = m_pc + 32'd4;
        m_mis = 0;
        if (r) begin
            model_reset();
        end else if (!m_booted) begin
            m_booted = 1;
        end else if (m_pending) begin
            if (rdy) begin
                model_go_to(rv ? tgt : m_pending_tgt);
                m_pending = 0;
            end else if (rv) begin
                m_pending_tgt = tgt;
            end
        end else if (rv) begin
            if (rdy) model_go_to(tgt);
            else begin
                m_pending = 1;
                m_pending_tgt = tgt;
            end
        end else if (rdy && !stl) begin
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
        end
        exp_q.push_back('{v: m_booted, pc: m_pc, cnt: m_cnt, mis: m_mis, bad: m_bad});
    endtask

    // Monitor: after every rising edge compare the DUT against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("valid", 32'(fetch_valid), 32'(e.v));
                check("pc", pc, e.pc);
                check("count", fetch_count, e.cnt);
                check("misalign", 32'(misalign), 32'(e.mis));
                check("bad_addr", bad_addr, e.bad);
            end
        end
    end

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit          r, rdy, stl, rv;
        logic [31:0] tgt;
        model_reset();

        // Reset, release, boot cycle
        cycle(1, 0, 0, 0, 32'h0);
        cycle(1, 1, 0, 1, 32'h40);
        after_edge();
        check("reset_pc", pc, 32'h0);
        check("reset_valid", 32'(fetch_valid), 32'h0);
        cycle(0, 1, 0, 1, 32'h80);
        after_edge();
        check("boot_valid", 32'(fetch_valid), 32'h1);
        check("boot_pc_redirect_ignored", pc, 32'h0);

        // Sequential advance
        repeat (3) cycle(0, 1, 0, 0, 32'h0);
        after_edge();
        check("seq_pc", pc, 32'hC);
        check("seq_count", fetch_count, 32'd3);

        // Stalled fires hold PC and count
        repeat (2) cycle(0, 1, 1, 0, 32'h0);
        after_edge();
        check("stall_pc", pc, 32'hC);
        check("stall_count", fetch_count, 32'd3);
        cycle(0, 1, 0, 0, 32'h0);
        after_edge();
        check("stall_release_pc", pc, 32'h10);

        // Redirects while not ready: youngest wins
        cycle(0, 0, 0, 1, 32'h100);
        cycle(0, 0, 0, 1, 32'h200);
        after_edge();
        check("pend_hold_pc", pc, 32'h10);
        cycle(0, 1, 0, 0, 32'h0);
        after_edge();
        check("pend_release_pc", pc, 32'h200);

        // Redirect overrides stall; misaligned target
        cycle(0, 1, 1, 1, 32'h102);
        after_edge();
`ifdef MISALIGN_TRAP_EN
        check("misalign_pc", pc, TV);
        check("misalign_pulse", 32'(misalign), 32'h1);
        check("misalign_bad", bad_addr, 32'h102);
`else
        check("misalign_pc", pc, 32'h100);
`endif
        cycle(0, 0, 0, 0, 32'h0);
        after_edge();
        check("misalign_pulse_end", 32'(misalign), 32'h0);

        // PC wrap via adder
        cycle(0, 1, 0, 1, 32'hFFFF_FFFC);
        cycle(0, 1, 0, 0, 32'h0);
        after_edge();
        check("wrap_pc", pc, 32'h0);

        // Reset while a redirect is pending
        cycle(0, 0, 0, 1, 32'h300);
        cycle(1, 0, 0, 0, 32'h0);
        #1;
        check("async_reset_pc", pc, RV);
        check("async_reset_valid", 32'(fetch_valid), 32'h0);
        cycle(0, 1, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 32'h0);
        after_edge();
        check("pend_lost_pc", pc, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            stl = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 4) == 0);
            tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            if ($urandom_range(0, 1) == 1) tgt[1:0] = 2'b00;
            cycle(r, rdy, stl, rv, tgt);
        end

        repeat (3) after_edge();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
